// File: rtl/mm_pkg.sv
// Shared types and width/index helpers for the parametrised matrix multiplier.
package mm_pkg;

  typedef enum logic [1:0] {
    MM_IDLE    = 2'd0,
    MM_COMPUTE = 2'd1,
    MM_DONE    = 2'd2
  } mm_state_e;

  // Element address width; a 1x1 matrix still needs a 1-bit address port.
  function automatic int unsigned mm_aw(input int unsigned n);
    return (n * n > 1) ? int'($clog2(n * n)) : 1;
  endfunction

  // Result width: full product plus headroom for N accumulated terms.
  function automatic int unsigned mm_ow(input int unsigned n, input int unsigned dw);
    return 2 * dw + int'($clog2(n));
  endfunction

  // Loop-counter width for i, j, k.
  function automatic int unsigned mm_cw(input int unsigned n);
    return (n > 1) ? int'($clog2(n)) : 1;
  endfunction

  function automatic int unsigned mm_idx(input int unsigned row, input int unsigned col,
                                         input int unsigned n);
    return row * n + col;
  endfunction

endpackage

// File: rtl/mm_mac_unit.sv
// Single multiply-accumulate lane: DW x DW product added into an OW-bit registered
// accumulator; SIGNED_EN selects two's-complement or unsigned arithmetic.
module mm_mac_unit #(
  parameter int unsigned DW        = 8,
  parameter int unsigned OW        = 17,
  parameter bit          SIGNED_EN = 1'b0
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_clr,
  input  logic          i_en,
  input  logic [DW-1:0] i_a,
  input  logic [DW-1:0] i_b,
  output logic [OW-1:0] o_sum_c
);

  localparam int unsigned PW = 2 * DW;

  logic [OW-1:0] w_prod;
  logic [OW-1:0] r_acc;

  generate
    if (SIGNED_EN) begin : g_signed
      logic signed [PW-1:0] w_prod_s;
      assign w_prod_s = PW'($signed(i_a)) * PW'($signed(i_b));
      assign w_prod   = OW'(w_prod_s);
    end else begin : g_unsigned
      logic [PW-1:0] w_prod_u;
      assign w_prod_u = PW'(i_a) * PW'(i_b);
      assign w_prod   = OW'(w_prod_u);
    end
  endgenerate

  assign o_sum_c = r_acc + w_prod;

  // Clear wins over accumulate so the final MAC of a dot product restarts at zero.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_acc <= '0;
    end else if (i_clr) begin
      r_acc <= '0;
    end else if (i_en) begin
      r_acc <= o_sum_c;
    end
  end

endmodule

// File: rtl/matrix_multiply_param.sv
// NxN matrix multiplier: operand load port, sequential single-MAC compute, registered read.
// Define MM_SIGNED_EN for two's-complement arithmetic; undefined builds are unsigned.
module matrix_multiply_param
  import mm_pkg::*;
#(
  parameter  int unsigned N  = 2,
  parameter  int unsigned DW = 8,
  localparam int unsigned AW = mm_aw(N),
  localparam int unsigned OW = mm_ow(N, DW)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load_valid,
  output logic          load_ready,
  input  logic          load_mat,
  input  logic [AW-1:0] load_addr,
  input  logic [DW-1:0] load_data,
  input  logic          execute,
  output logic          busy,
  output logic          done,
  input  logic [AW-1:0] rd_addr,
  output logic [OW-1:0] rd_data
);

  localparam int unsigned NN = N * N;
  localparam int unsigned CW = mm_cw(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);
`ifdef MM_SIGNED_EN
  localparam bit SIGNED_EN = 1'b1;
`else
  localparam bit SIGNED_EN = 1'b0;
`endif

  mm_state_e     r_state;
  mm_state_e     w_state_nxt;
  logic          r_load_ready;
  logic          r_busy;
  logic          r_done;
  logic [OW-1:0] r_rd_data;

  logic [DW-1:0] r_a [NN];
  logic [DW-1:0] r_b [NN];
  logic [OW-1:0] r_c [NN];
  logic [CW-1:0] r_i;
  logic [CW-1:0] r_j;
  logic [CW-1:0] r_k;

  logic          w_load_acc;
  logic          w_start;
  logic          w_mac_en;
  logic          w_k_last;
  logic          w_last;
  logic          w_load_in_range;
  logic          w_rd_in_range;
  logic [AW-1:0] w_load_idx;
  logic [AW-1:0] w_rd_idx;
  logic [AW-1:0] w_a_idx;
  logic [AW-1:0] w_b_idx;
  logic [AW-1:0] w_c_idx;
  logic [DW-1:0] w_op_a;
  logic [DW-1:0] w_op_b;
  logic [OW-1:0] w_sum_c;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= MM_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Execute takes priority over an accepted load when both arrive in DONE.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      MM_IDLE:    if (w_start) w_state_nxt = MM_COMPUTE;
      MM_COMPUTE: if (w_last) w_state_nxt = MM_DONE;
      MM_DONE: begin
        if (w_start)         w_state_nxt = MM_COMPUTE;
        else if (w_load_acc) w_state_nxt = MM_IDLE;
      end
      default:    w_state_nxt = MM_IDLE;
    endcase
  end

  always_comb begin
    w_load_acc = load_valid & r_load_ready;
    w_start    = execute & (r_state != MM_COMPUTE);
    w_mac_en   = (r_state == MM_COMPUTE);
    w_k_last   = w_mac_en & (r_k == LAST);
    w_last     = w_k_last & (r_j == LAST) & (r_i == LAST);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_load_ready <= 1'b1;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_load_ready <= (w_state_nxt != MM_COMPUTE);
      r_busy       <= (w_state_nxt == MM_COMPUTE);
      r_done       <= (w_state_nxt == MM_DONE);
    end
  end

  // Out-of-range addresses are steered to index 0 and then gated off.
  always_comb begin
    w_load_in_range = (32'(load_addr) < NN);
    w_rd_in_range   = (32'(rd_addr) < NN);
    w_load_idx      = w_load_in_range ? load_addr : '0;
    w_rd_idx        = w_rd_in_range ? rd_addr : '0;
    w_a_idx         = AW'(mm_idx(32'(r_i), 32'(r_k), N));
    w_b_idx         = AW'(mm_idx(32'(r_k), 32'(r_j), N));
    w_c_idx         = AW'(mm_idx(32'(r_i), 32'(r_j), N));
    w_op_a          = r_a[w_a_idx];
    w_op_b          = r_b[w_b_idx];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int n = 0; n < NN; n++) begin
        r_a[AW'(n)] <= '0;
        r_b[AW'(n)] <= '0;
      end
    end else if (w_load_acc && w_load_in_range) begin
      if (load_mat) r_b[w_load_idx] <= load_data;
      else          r_a[w_load_idx] <= load_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int n = 0; n < NN; n++) r_c[AW'(n)] <= '0;
    end else if (w_start) begin
      for (int n = 0; n < NN; n++) r_c[AW'(n)] <= '0;
    end else if (w_k_last) begin
      r_c[w_c_idx] <= w_sum_c;
    end
  end

  // k runs fastest, then j, then i; all wrap to zero after the final MAC.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_i <= '0;
      r_j <= '0;
      r_k <= '0;
    end else if (w_start || w_last) begin
      r_i <= '0;
      r_j <= '0;
      r_k <= '0;
    end else if (w_mac_en) begin
      if (r_k != LAST) begin
        r_k <= r_k + CW'(1);
      end else begin
        r_k <= '0;
        if (r_j != LAST) begin
          r_j <= r_j + CW'(1);
        end else begin
          r_j <= '0;
          r_i <= r_i + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rd_data <= '0;
    end else begin
      r_rd_data <= w_rd_in_range ? r_c[w_rd_idx] : '0;
    end
  end

  mm_mac_unit #(
    .DW        (DW),
    .OW        (OW),
    .SIGNED_EN (SIGNED_EN)
  ) u_mac (
    .i_clk   (clk),
    .i_rst_n (reset),
    .i_clr   (w_start | w_k_last),
    .i_en    (w_mac_en),
    .i_a     (w_op_a),
    .i_b     (w_op_b),
    .o_sum_c (w_sum_c)
  );

  assign load_ready = r_load_ready;
  assign busy       = r_busy;
  assign done       = r_done;
  assign rd_data    = r_rd_data;

endmodule

// File: tb/tb_matrix_multiply_param.sv
// Directed bench for matrix_multiply_param: a 2x2/8-bit instance plus a 3x3/4-bit
// instance for out-of-range addressing; MM_SIGNED_EN switches signed expectations.
`timescale 1ns/1ps
module tb_matrix_multiply_param;

  localparam int unsigned DW  = 8;
  localparam int unsigned AW  = 2;
  localparam int unsigned OW  = 17;
  localparam int unsigned AW3 = 4;
  localparam int unsigned DW3 = 4;
  localparam int unsigned OW3 = 10;

  typedef int vec_t [4];

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          load_valid = 1'b0;
  logic          load_ready;
  logic          load_mat = 1'b0;
  logic [AW-1:0] load_addr = '0;
  logic [DW-1:0] load_data = '0;
  logic          execute = 1'b0;
  logic          busy;
  logic          done;
  logic [AW-1:0] rd_addr = '0;
  logic [OW-1:0] rd_data;

  logic           t3_load_valid = 1'b0;
  logic           t3_load_ready;
  logic           t3_load_mat = 1'b0;
  logic [AW3-1:0] t3_load_addr = '0;
  logic [DW3-1:0] t3_load_data = '0;
  logic           t3_execute = 1'b0;
  logic           t3_busy;
  logic           t3_done;
  logic [AW3-1:0] t3_rd_addr = '0;
  logic [OW3-1:0] t3_rd_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  matrix_multiply_param #(.N(2), .DW(8)) u_dut (
    .clk        (clk),
    .reset      (reset),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_mat   (load_mat),
    .load_addr  (load_addr),
    .load_data  (load_data),
    .execute    (execute),
    .busy       (busy),
    .done       (done),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data)
  );

  matrix_multiply_param #(.N(3), .DW(4)) u_dut3 (
    .clk        (clk),
    .reset      (reset),
    .load_valid (t3_load_valid),
    .load_ready (t3_load_ready),
    .load_mat   (t3_load_mat),
    .load_addr  (t3_load_addr),
    .load_data  (t3_load_data),
    .execute    (t3_execute),
    .busy       (t3_busy),
    .done       (t3_done),
    .rd_addr    (t3_rd_addr),
    .rd_data    (t3_rd_data)
  );

  task automatic load_elem(input logic mat, input int addr, input int data);
    load_mat   = mat;
    load_addr  = AW'(addr);
    load_data  = DW'(data);
    load_valid = 1'b1;
    @(posedge clk); #1;
    load_valid = 1'b0;
  endtask

  task automatic load_mats(input vec_t a, input vec_t b);
    for (int n = 0; n < 4; n++) load_elem(1'b0, n, a[n]);
    for (int n = 0; n < 4; n++) load_elem(1'b1, n, b[n]);
  endtask

  task automatic wait_done(output int edges);
    edges = 0;
    while (done !== 1'b1 && edges < 40) begin
      @(posedge clk); #1;
      edges++;
    end
  endtask

  task automatic run_compute(output int edges);
    execute = 1'b1;
    @(posedge clk); #1;
    execute = 1'b0;
    wait_done(edges);
  endtask

  task automatic read_c(input int addr, output logic [OW-1:0] v);
    rd_addr = AW'(addr);
    @(posedge clk); #1;
    v = rd_data;
  endtask

  task automatic test_reset();
    logic [OW-1:0] v;
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({busy, done, load_ready} !== 3'b001 || rd_data !== '0) begin
      errors++;
      $display("FAIL reset_outputs busy=%b done=%b ready=%b rd=%0d expected 0 0 1 0",
               busy, done, load_ready, rd_data);
    end
    #20 reset = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (load_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready got %b expected 1", load_ready);
    end
    read_c(3, v);
    checks++;
    if (v !== '0) begin
      errors++;
      $display("FAIL reset_c3 got %0d expected 0", v);
    end
  endtask

  task automatic test_basic();
    vec_t a = '{1, 2, 3, 4};
    vec_t b = '{5, 6, 7, 8};
    logic [OW-1:0] expc [4] = '{17'd19, 17'd22, 17'd43, 17'd50};
    logic [OW-1:0] v;
    int edges;
    load_mats(a, b);
    execute = 1'b1;
    @(posedge clk); #1;
    execute = 1'b0;
    checks++;
    if ({busy, load_ready, done} !== 3'b100) begin
      errors++;
      $display("FAIL basic_start busy/ready/done got %b expected 100", {busy, load_ready, done});
    end
    wait_done(edges);
    checks++;
    if (edges != 8) begin
      errors++;
      $display("FAIL basic_latency got %0d edges expected 8", edges);
    end
    checks++;
    if ({busy, load_ready} !== 2'b01) begin
      errors++;
      $display("FAIL basic_idle busy/ready got %b expected 01", {busy, load_ready});
    end
    for (int n = 0; n < 4; n++) begin
      read_c(n, v);
      checks++;
      if (v !== expc[n]) begin
        errors++;
        $display("FAIL basic_c%0d got %0d expected %0d", n, v, expc[n]);
      end
    end
    read_c(0, v);
    rd_addr = AW'(1);
    #1;
    checks++;
    if (rd_data !== 17'd19) begin
      errors++;
      $display("FAIL read_latency_hold got %0d expected 19", rd_data);
    end
    @(posedge clk); #1;
    checks++;
    if (rd_data !== 17'd22) begin
      errors++;
      $display("FAIL read_latency_update got %0d expected 22", rd_data);
    end
  endtask

  task automatic test_full_range();
    vec_t a = '{255, 255, 255, 255};
    logic [OW-1:0] v;
    logic [OW-1:0] exp_v;
    int edges;
`ifdef MM_SIGNED_EN
    exp_v = 17'd2;
`else
    exp_v = 17'h1FC02;
`endif
    load_mats(a, a);
    run_compute(edges);
    checks++;
    if (edges != 8) begin
      errors++;
      $display("FAIL full_latency got %0d expected 8", edges);
    end
    for (int n = 0; n < 4; n++) begin
      read_c(n, v);
      checks++;
      if (v !== exp_v) begin
        errors++;
        $display("FAIL full_c%0d got %0h expected %0h", n, v, exp_v);
      end
    end
  endtask

  task automatic test_execute_ignored();
    vec_t a = '{1, 2, 3, 4};
    vec_t b = '{5, 6, 7, 8};
    logic [OW-1:0] expc [4] = '{17'd19, 17'd22, 17'd43, 17'd50};
    logic [OW-1:0] v;
    int edges;
    load_mats(a, b);
    execute = 1'b1;
    @(posedge clk); #1;
    execute = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    checks++;
    if ({load_ready, busy} !== 2'b01) begin
      errors++;
      $display("FAIL busy_ready ready/busy got %b expected 01", {load_ready, busy});
    end
    execute    = 1'b1;
    load_valid = 1'b1;
    load_mat   = 1'b0;
    load_addr  = '0;
    load_data  = DW'(99);
    @(posedge clk); #1;
    execute    = 1'b0;
    load_valid = 1'b0;
    wait_done(edges);
    edges += 4;
    checks++;
    if (edges != 8) begin
      errors++;
      $display("FAIL ignored_latency got %0d edges expected 8", edges);
    end
    for (int n = 0; n < 4; n++) begin
      read_c(n, v);
      checks++;
      if (v !== expc[n]) begin
        errors++;
        $display("FAIL ignored_c%0d got %0d expected %0d", n, v, expc[n]);
      end
    end
  endtask

  task automatic test_reset_mid_compute();
    logic [OW-1:0] v;
    int edges;
    rd_addr = '0;
    execute = 1'b1;
    @(posedge clk); #1;
    execute = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
    end
    checks++;
    if (rd_data !== 17'd19 || busy !== 1'b1) begin
      errors++;
      $display("FAIL partial_c0 got %0d busy=%b expected 19 busy=1", rd_data, busy);
    end
    reset = 1'b0;
    #1;
    checks++;
    if ({busy, done} !== 2'b00 || rd_data !== '0) begin
      errors++;
      $display("FAIL midreset_async busy=%b done=%b rd=%0d expected 0 0 0", busy, done, rd_data);
    end
    #3 reset = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({load_ready, busy, done} !== 3'b100) begin
      errors++;
      $display("FAIL midreset_release ready/busy/done got %b expected 100",
               {load_ready, busy, done});
    end
    for (int n = 0; n < 4; n++) begin
      read_c(n, v);
      checks++;
      if (v !== '0) begin
        errors++;
        $display("FAIL midreset_c%0d got %0d expected 0", n, v);
      end
    end
    run_compute(edges);
    read_c(3, v);
    checks++;
    if (edges != 8 || v !== '0) begin
      errors++;
      $display("FAIL midreset_operands_cleared edges=%0d c3=%0d expected 8 0", edges, v);
    end
  endtask

  task automatic test_back_to_back();
    vec_t a = '{1, 2, 3, 4};
    vec_t b = '{5, 6, 7, 8};
    logic [OW-1:0] expc [4] = '{17'd39, 17'd46, 17'd43, 17'd50};
    logic [OW-1:0] v;
    int edges;
    load_mats(a, b);
    run_compute(edges);
    read_c(1, v);
    read_c(2, v);
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL done_sticky got %b expected 1", done);
    end
    load_valid = 1'b1;
    load_mat   = 1'b0;
    load_addr  = '0;
    load_data  = DW'(5);
    execute    = 1'b1;
    @(posedge clk); #1;
    load_valid = 1'b0;
    execute    = 1'b0;
    checks++;
    if ({busy, done} !== 2'b10) begin
      errors++;
      $display("FAIL restart_from_done busy/done got %b expected 10", {busy, done});
    end
    wait_done(edges);
    checks++;
    if (edges != 8) begin
      errors++;
      $display("FAIL restart_latency got %0d expected 8", edges);
    end
    for (int n = 0; n < 4; n++) begin
      read_c(n, v);
      checks++;
      if (v !== expc[n]) begin
        errors++;
        $display("FAIL sameedge_c%0d got %0d expected %0d", n, v, expc[n]);
      end
    end
    load_elem(1'b1, 0, 5);
    checks++;
    if ({done, load_ready, busy} !== 3'b010) begin
      errors++;
      $display("FAIL load_clears_done done/ready/busy got %b expected 010",
               {done, load_ready, busy});
    end
  endtask

  task automatic test_out_of_range();
    int bv [9] = '{1, 2, 3, 4, 5, 6, 7, 1, 2};
    int edges;
    for (int n = 0; n < 18; n++) begin
      t3_load_mat   = (n >= 9);
      t3_load_addr  = AW3'(n % 9);
      t3_load_data  = (n >= 9) ? DW3'(bv[n - 9]) : ((n % 4 == 0) ? DW3'(1) : DW3'(0));
      t3_load_valid = 1'b1;
      @(posedge clk); #1;
    end
    for (int n = 9; n < 16; n++) begin
      t3_load_mat  = n[0];
      t3_load_addr = AW3'(n);
      t3_load_data = DW3'(15);
      @(posedge clk); #1;
    end
    t3_load_valid = 1'b0;
    t3_execute    = 1'b1;
    @(posedge clk); #1;
    t3_execute = 1'b0;
    edges = 0;
    while (t3_done !== 1'b1 && edges < 100) begin
      @(posedge clk); #1;
      edges++;
    end
    checks++;
    if (edges != 27) begin
      errors++;
      $display("FAIL n3_latency got %0d edges expected 27", edges);
    end
    for (int n = 0; n < 9; n++) begin
      t3_rd_addr = AW3'(n);
      @(posedge clk); #1;
      checks++;
      if (t3_rd_data !== OW3'(bv[n])) begin
        errors++;
        $display("FAIL n3_c%0d got %0d expected %0d", n, t3_rd_data, bv[n]);
      end
    end
    t3_rd_addr = AW3'(9);
    @(posedge clk); #1;
    checks++;
    if (t3_rd_data !== '0) begin
      errors++;
      $display("FAIL n3_rd_oob9 got %0d expected 0", t3_rd_data);
    end
    t3_rd_addr = AW3'(15);
    @(posedge clk); #1;
    checks++;
    if (t3_rd_data !== '0) begin
      errors++;
      $display("FAIL n3_rd_oob15 got %0d expected 0", t3_rd_data);
    end
  endtask

`ifdef MM_SIGNED_EN
  task automatic test_signed();
    vec_t m80 = '{8'h80, 8'h80, 8'h80, 8'h80};
    vec_t a   = '{8'hFF, 0, 0, 8'hFF};
    vec_t b   = '{3, 4, 5, 6};
    logic [OW-1:0] expc [4] = '{17'h1FFFD, 17'h1FFFC, 17'h1FFFB, 17'h1FFFA};
    logic [OW-1:0] v;
    int edges;
    load_mats(m80, m80);
    run_compute(edges);
    for (int n = 0; n < 4; n++) begin
      read_c(n, v);
      checks++;
      if (v !== 17'h08000) begin
        errors++;
        $display("FAIL signed_min_c%0d got %0h expected 8000", n, v);
      end
    end
    load_mats(a, b);
    run_compute(edges);
    for (int n = 0; n < 4; n++) begin
      read_c(n, v);
      checks++;
      if (v !== expc[n]) begin
        errors++;
        $display("FAIL signed_neg_c%0d got %0h expected %0h", n, v, expc[n]);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_full_range();
    test_execute_ignored();
    test_reset_mid_compute();
    test_back_to_back();
    test_out_of_range();
`ifdef MM_SIGNED_EN
    test_signed();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
